fft_rd_sched: RTL and testbench

- Read-request scheduler for the FFT accelerator input path.
- On a start pulse, fetches a host buffer of size_cl cache lines starting at base_addr through the CCI-P c0 read channel, one request per cycle.
- Throttles on c0 almost-full and on downstream sink credits.
- Forwards read responses, tagged with their line index, to the FFT input buffer. Sits between the MMIO/control decode and the FFT input FIFO.

---
 rtl/fft_rd_sched.sv | 149 ++++++++++++++
 tb/tb_fft_rd_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_rd_sched.sv
`timescale 1ns/1ps
// Read-request scheduler for the FFT input path: fetches a host buffer over the
// CCI-P c0 channel under almost-full and sink-credit throttling, forwards tagged responses.
module fft_rd_sched #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [41:0]      base_addr,
    input  logic [CNT_W-1:0] size_cl,
    input  logic             c0_almfull,
    output logic             rd_req_valid,
    output logic [41:0]      rd_req_addr,
    output logic [15:0]      rd_req_mdata,
    input  logic             rd_rsp_valid,
    input  logic [511:0]     rd_rsp_data,
    input  logic [15:0]      rd_rsp_mdata,
    input  logic             sink_pop,
    output logic             out_valid,
    output logic [511:0]     out_data,
    output logic [15:0]      out_idx,
    output logic             busy,
    output logic             done
);

    localparam int CRD_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        S_RD_IDLE,
        S_RD_FETCH,
        S_RD_WAIT,
        S_RD_FINISH
    } state_t;

    state_t           r_state;
    logic [41:0]      r_base;
    logic [CNT_W-1:0] r_size;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_received;
    logic [CRD_W-1:0] r_credits;

    logic             r_rd_req_valid;
    logic [41:0]      r_rd_req_addr;
    logic [15:0]      r_rd_req_mdata;
    logic             r_out_valid;
    logic [511:0]     r_out_data;
    logic [15:0]      r_out_idx;
    logic             r_busy;
    logic             r_done;

    logic             w_can_issue;
    logic             w_rsp_accept;
    logic             w_credit_full;
    logic [CNT_W-1:0] w_issued_inc;
    logic [CNT_W-1:0] w_received_next;

    // Issue decision uses almost-full as seen this cycle; the request itself
    // appears registered on the next cycle.
    assign w_can_issue     = (r_state == S_RD_FETCH) && !c0_almfull &&
                             (r_credits != '0) && (r_issued < r_size);
    assign w_rsp_accept    = rd_rsp_valid && (r_state != S_RD_IDLE);
    assign w_credit_full   = (r_credits == CRD_W'(MAX_OUTSTANDING));
    assign w_issued_inc    = r_issued + CNT_W'(1);
    assign w_received_next = r_received + CNT_W'(w_rsp_accept);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_RD_IDLE;
            r_base         <= '0;
            r_size         <= '0;
            r_issued       <= '0;
            r_received     <= '0;
            r_credits      <= CRD_W'(MAX_OUTSTANDING);
            r_rd_req_valid <= 1'b0;
            r_rd_req_addr  <= '0;
            r_rd_req_mdata <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_idx      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_rd_req_valid <= 1'b0;
            r_done         <= 1'b0;
            r_out_valid    <= w_rsp_accept;

            if (w_rsp_accept) begin
                r_out_data <= rd_rsp_data;
                r_out_idx  <= rd_rsp_mdata;
                r_received <= w_received_next;
            end

            // A pop arriving with the pool already full is dropped rather than overflowing.
            case ({w_can_issue, sink_pop})
                2'b10:   r_credits <= r_credits - CRD_W'(1);
                2'b01:   if (!w_credit_full) r_credits <= r_credits + CRD_W'(1);
                default: r_credits <= r_credits;
            endcase

            if (w_can_issue) begin
                r_rd_req_valid <= 1'b1;
                r_rd_req_addr  <= r_base + 42'(r_issued);
                r_rd_req_mdata <= r_issued[15:0];
                r_issued       <= w_issued_inc;
            end

            case (r_state)
                S_RD_IDLE: begin
                    if (start) begin
                        r_base     <= base_addr;
                        r_size     <= size_cl;
                        r_issued   <= '0;
                        r_received <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= (size_cl != '0) ? S_RD_FETCH : S_RD_FINISH;
                    end
                end
                S_RD_FETCH: begin
                    if (w_can_issue && (w_issued_inc == r_size)) begin
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (w_received_next >= r_size) begin
                        r_state <= S_RD_FINISH;
                    end
                end
                S_RD_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_RD_IDLE;
                end
                default: r_state <= S_RD_IDLE;
            endcase
        end
    end

    assign rd_req_valid = r_rd_req_valid;
    assign rd_req_addr  = r_rd_req_addr;
    assign rd_req_mdata = r_rd_req_mdata;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_idx      = r_out_idx;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_fft_rd_sched.sv
`timescale 1ns/1ps
// Directed bench for fft_rd_sched: a cycle-stepped host/sink model with a request
// scoreboard and an output scoreboard fed as responses are driven.
module tb_fft_rd_sched;

    localparam int MAXO = 4;
    localparam int CW   = 32;

    logic           clk;
    logic           reset;
    logic           start;
    logic [41:0]    base_addr;
    logic [CW-1:0]  size_cl;
    logic           c0_almfull;
    logic           rd_req_valid;
    logic [41:0]    rd_req_addr;
    logic [15:0]    rd_req_mdata;
    logic           rd_rsp_valid;
    logic [511:0]   rd_rsp_data;
    logic [15:0]    rd_rsp_mdata;
    logic           sink_pop;
    logic           out_valid;
    logic [511:0]   out_data;
    logic [15:0]    out_idx;
    logic           busy;
    logic           done;

    fft_rd_sched #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .size_cl      (size_cl),
        .c0_almfull   (c0_almfull),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_mdata (rd_req_mdata),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_mdata (rd_rsp_mdata),
        .sink_pop     (sink_pop),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .busy         (busy),
        .done         (done)
    );

    typedef struct { logic [41:0] addr; logic [15:0] tag; } req_t;
    typedef struct { int due; logic [41:0] addr; logic [15:0] tag; } rsp_t;
    typedef struct { logic [15:0] tag; logic [511:0] data; } out_t;

    req_t expReq[$];
    rsp_t pend[$];
    out_t expOut[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int reqCount, outCount, doneCount;
    int firstReqCycle, lastReqCycle, doneCycle, startCyc;
    int pendingPops, manualPops, rawPops;
    int almLo, almHi;
    int outBase, doneBase;
    bit autoRespond, autoPop, dropResp;
    int order5[4] = '{3, 1, 0, 2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [511:0] lineData(input logic [41:0] a);
        return {16{a[31:0] ^ 32'h5A5A_0000}};
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: DUT samples at posedge, bench observes and drives at negedge.
    task automatic tick();
        logic almAtEdge;
        req_t er;
        rsp_t pr;
        out_t eo;
        almAtEdge = c0_almfull;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rd_req_valid) begin
            reqCount++;
            if (reqCount == 1) firstReqCycle = cyc;
            lastReqCycle = cyc;
            checkOutput("req_while_almfull", almAtEdge, 1'b0);
            checkOutput("req_expected", expReq.size() != 0, 1'b1);
            if (expReq.size() != 0) begin
                er = expReq.pop_front();
                checkOutput("req_addr", rd_req_addr, er.addr);
                checkOutput("req_mdata", rd_req_mdata, er.tag);
            end
            if (autoRespond) pend.push_back('{cyc + 3, rd_req_addr, rd_req_mdata});
        end
        if (out_valid) begin
            outCount++;
            pendingPops++;
            checkOutput("out_expected", expOut.size() != 0, 1'b1);
            if (expOut.size() != 0) begin
                eo = expOut.pop_front();
                checkOutput("out_idx", out_idx, eo.tag);
                checkOutput("out_data", out_data, eo.data);
            end
        end
        if (done) begin
            doneCount++;
            doneCycle = cyc;
            checkOutput("busy_with_done", busy, 1'b0);
        end
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        rd_rsp_mdata = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            pr = pend.pop_front();
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = lineData(pr.addr);
            rd_rsp_mdata = pr.tag;
            if (!dropResp) expOut.push_back('{pr.tag, lineData(pr.addr)});
        end
        sink_pop = 1'b0;
        if (rawPops > 0) begin
            sink_pop = 1'b1;
            rawPops--;
        end else if (pendingPops > 0 && (autoPop || manualPops > 0)) begin
            sink_pop = 1'b1;
            pendingPops--;
            if (!autoPop) manualPops--;
        end
        c0_almfull = (cyc >= almLo) && (cyc <= almHi);
    endtask

    task automatic applyStimulus(input logic [41:0] b, input int s, input bit pushExp);
        base_addr = b;
        size_cl   = CW'(s);
        start     = 1'b1;
        if (pushExp) for (int i = 0; i < s; i++) expReq.push_back('{b + 42'(i), 16'(i)});
        startCyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int base;
        int n;
        base = doneCount;
        n = 0;
        while (doneCount == base && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, doneCount - base, 1);
    endtask

    task automatic waitReqs(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (reqCount < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, reqCount, target);
    endtask

    task automatic beginRun();
        expReq.delete();
        pend.delete();
        expOut.delete();
        reqCount = 0; outCount = 0; doneCount = 0;
        firstReqCycle = 0; lastReqCycle = 0; doneCycle = 0;
        pendingPops = 0; manualPops = 0; rawPops = 0;
        autoRespond = 1'b1; autoPop = 1'b1; dropResp = 1'b0;
        almLo = 1; almHi = 0;
    endtask

    task automatic endRun(input string tag);
        repeat (8) tick();
        checkOutput({tag, "_reqs_left"}, expReq.size(), 0);
        checkOutput({tag, "_outs_left"}, expOut.size(), 0);
        checkOutput({tag, "_pops_left"}, pendingPops, 0);
        checkOutput({tag, "_done_once"}, doneCount, 1);
        checkOutput({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; size_cl = '0; c0_almfull = 1'b0;
        rd_rsp_valid = 1'b0; rd_rsp_data = '0; rd_rsp_mdata = '0; sink_pop = 1'b0;
        beginRun();
        tick();
        tick();
        checkOutput("rst_req_valid", rd_req_valid, 1'b0);
        checkOutput("rst_req_addr", rd_req_addr, 42'h0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_idx", out_idx, 16'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        reset = 1'b0;
        tick();

        // Basic 4-line fetch
        beginRun();
        applyStimulus(42'h1000, 4, 1'b1);
        checkOutput("t1_busy_after_start", busy, 1'b1);
        waitDone(60, "t1_done");
        checkOutput("t1_first_req_latency", firstReqCycle - startCyc, 2);
        checkOutput("t1_back_to_back", lastReqCycle - firstReqCycle, 3);
        endRun("t1");
        checkOutput("t1_out_count", outCount, 4);

        // Almost-full stall in cycles 3..7 after start
        beginRun();
        almLo = cyc + 3;
        almHi = cyc + 7;
        applyStimulus(42'h2_0000, 6, 1'b1);
        waitDone(80, "t2_done");
        checkOutput("t2_resume_timing", lastReqCycle - startCyc, 12);
        endRun("t2");
        checkOutput("t2_req_count", reqCount, 6);
        checkOutput("t2_out_count", outCount, 6);

        // Credit exhaustion and release
        beginRun();
        autoPop = 1'b0;
        applyStimulus(42'h3000, 10, 1'b1);
        repeat (20) tick();
        checkOutput("t3_stall_at_credits", reqCount, 4);
        manualPops = 1;
        repeat (6) tick();
        checkOutput("t3_pop_releases_one", reqCount, 5);
        manualPops = 1;
        repeat (6) tick();
        checkOutput("t3_pop_releases_two", reqCount, 6);
        autoPop = 1'b1;
        waitDone(120, "t3_done");
        endRun("t3");
        checkOutput("t3_req_count", reqCount, 10);

        // Zero-length buffer
        beginRun();
        applyStimulus(42'h4000, 0, 1'b1);
        checkOutput("t4_busy", busy, 1'b1);
        waitDone(10, "t4_done");
        checkOutput("t4_done_latency", doneCycle - startCyc, 2);
        endRun("t4");
        checkOutput("t4_req_count", reqCount, 0);
        checkOutput("t4_out_count", outCount, 0);

        // Out-of-order responses; start while busy must be ignored
        beginRun();
        autoRespond = 1'b0;
        autoPop = 1'b0;
        applyStimulus(42'h5000, 4, 1'b1);
        waitReqs(1, 10, "t5_first_req");
        applyStimulus(42'h9_9999, 3, 1'b0);
        waitReqs(4, 20, "t5_reqs");
        checkOutput("t5_back_to_back", lastReqCycle - firstReqCycle, 3);
        for (int i = 0; i < 4; i++)
            pend.push_back('{cyc + 1 + i, 42'h5000 + 42'(order5[i]), 16'(order5[i])});
        waitDone(30, "t5_done");
        checkOutput("t5_last_idx", out_idx, 16'd2);
        autoPop = 1'b1;
        endRun("t5");
        checkOutput("t5_req_count", reqCount, 4);
        checkOutput("t5_out_count", outCount, 4);

        // Reset mid-fetch, late responses dropped, clean restart
        beginRun();
        autoRespond = 1'b0;
        autoPop = 1'b0;
        applyStimulus(42'h6000, 8, 1'b1);
        waitReqs(3, 20, "t6_reqs");
        reset = 1'b1;
        tick();
        tick();
        checkOutput("t6_rst_req_valid", rd_req_valid, 1'b0);
        checkOutput("t6_rst_busy", busy, 1'b0);
        checkOutput("t6_rst_done", done, 1'b0);
        checkOutput("t6_rst_req_count", reqCount, 3);
        expReq.delete();
        reset = 1'b0;
        dropResp = 1'b1;
        outBase = outCount;
        doneBase = doneCount;
        for (int i = 0; i < 3; i++) pend.push_back('{cyc + 1 + i, 42'h6000 + 42'(i), 16'(i)});
        repeat (6) tick();
        checkOutput("t6_late_out", outCount - outBase, 0);
        checkOutput("t6_late_done", doneCount - doneBase, 0);
        beginRun();
        autoPop = 1'b0;
        applyStimulus(42'h7000, 4, 1'b1);
        waitDone(40, "t6_restart_done");
        checkOutput("t6_full_credits", lastReqCycle - firstReqCycle, 3);
        autoPop = 1'b1;
        endRun("t6");
        checkOutput("t6_out_count", outCount, 4);

        // Pops at full credits ignored; address wraps modulo 2^42
        beginRun();
        autoPop = 1'b0;
        rawPops = 3;
        repeat (4) tick();
        applyStimulus(42'h3FF_FFFF_FFFE, 6, 1'b1);
        repeat (20) tick();
        checkOutput("t7_credit_cap", reqCount, 4);
        autoPop = 1'b1;
        waitDone(80, "t7_done");
        endRun("t7");
        checkOutput("t7_req_count", reqCount, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
